// File: rtl/con4_pkg.sv
// Shared Connect-4 definitions: board geometry, cell encoding and the
// controller's state encoding.
package con4_pkg;

  localparam int ROWS = 6;  // cells per column; cap >= ROWS means full
  localparam int COLS = 7;  // legal column indices are 0..COLS-1
  localparam int CW   = 3;  // width of column index and capacity counts

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    P1        = 2'b01,
    P2        = 2'b10,
    DRAW_FILL = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    P1_MOVE     = 3'd0,
    CHECK_1_WIN = 3'd1,
    WIN1        = 3'd2,
    P2_MOVE     = 3'd3,
    CHECK_2_WIN = 3'd4,
    WIN2        = 3'd5,
    CHECK_DRAW  = 3'd6,
    DRAW        = 3'd7
  } ctrl_state_t;

endpackage

// File: rtl/check_move_col_cap_mux.sv
// Column capacity selector: picks the fill count of the chosen column and
// flags an index that does not name a real column.
module col_cap_mux
  import con4_pkg::*;
(
  input  logic [COLS-1:0][CW-1:0] caps,
  input  logic [CW-1:0]           sel,
  output logic [CW-1:0]           cap,
  output logic                    bad_idx
);

  // Index decode; an out-of-range index yields cap 0 and raises bad_idx.
  always_comb begin
    cap     = '0;
    bad_idx = (sel >= CW'(COLS));
    for (int i = 0; i < COLS; i++) begin
      if (sel == CW'(i)) cap = caps[i];
    end
  end

endmodule

// File: rtl/check_move.sv
// Registered legality checker for a Connect-4 drop, plus per-column and
// whole-board full flags for the controller's draw check.
//
// Handshake: move_req is a bare strobe with no ready. Every edge at which
// move_req==1 (and rst==1) is one request; exactly one of valid_move or
// invalid_move pulses on the following cycle. Holding move_req high issues
// a new request every cycle.
module check_move
  import con4_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            move_req,
  input  logic [CW-1:0]   selected_move,
  input  logic [CW-1:0]   col0_cap,
  input  logic [CW-1:0]   col1_cap,
  input  logic [CW-1:0]   col2_cap,
  input  logic [CW-1:0]   col3_cap,
  input  logic [CW-1:0]   col4_cap,
  input  logic [CW-1:0]   col5_cap,
  input  logic [CW-1:0]   col6_cap,
  output logic            valid_move,
  output logic            invalid_move,
  output logic [CW-1:0]   target_row,
  output logic [COLS-1:0] col_full,
  output logic            board_full
);

  logic [COLS-1:0][CW-1:0] caps;
  logic [CW-1:0]           sel_cap;
  logic                    bad_idx;
  logic                    legal;
  logic [COLS-1:0]         full_next;

  assign caps = {col6_cap, col5_cap, col4_cap, col3_cap,
                 col2_cap, col1_cap, col0_cap};

  col_cap_mux u_col_cap_mux (
    .caps    (caps),
    .sel     (selected_move),
    .cap     (sel_cap),
    .bad_idx (bad_idx)
  );

  // A drop is legal into an existing column that still has a free cell.
  assign legal = !bad_idx && (sel_cap < CW'(ROWS));

  // Per-column full flags; the out-of-range cap value 7 also counts as full.
  always_comb begin
    full_next = '0;
    for (int i = 0; i < COLS; i++) begin
      full_next[i] = (caps[i] >= CW'(ROWS));
    end
  end

  // Output registers: request verdict, landing row and full flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_move   <= 1'b0;
      invalid_move <= 1'b0;
      target_row   <= '0;
      col_full     <= '0;
      board_full   <= 1'b0;
    end else begin
      valid_move   <= move_req && legal;
      invalid_move <= move_req && !legal;
      if (move_req && legal) target_row <= sel_cap;
      col_full     <= full_next;
      board_full   <= &full_next;
    end
  end

endmodule

// File: tb/tb_check_move.sv
// Bench for check_move: directed scenarios, an exhaustive column/cap sweep
// and random traffic, all compared against a rule-level reference model.
module tb_check_move;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  logic       clk;
  logic       rst;
  logic       move_req;
  logic [2:0] selected_move;
  logic [2:0] cap [COLS];
  logic       valid_move;
  logic       invalid_move;
  logic [2:0] target_row;
  logic [6:0] col_full;
  logic       board_full;

  int checks = 0;
  int errors = 0;

  // model expectations
  logic       exp_valid;
  logic       exp_invalid;
  logic [2:0] exp_row;
  logic [6:0] exp_full;
  logic       exp_board;

  check_move dut (
    .clk           (clk),
    .rst           (rst),
    .move_req      (move_req),
    .selected_move (selected_move),
    .col0_cap      (cap[0]),
    .col1_cap      (cap[1]),
    .col2_cap      (cap[2]),
    .col3_cap      (cap[3]),
    .col4_cap      (cap[4]),
    .col5_cap      (cap[5]),
    .col6_cap      (cap[6]),
    .valid_move    (valid_move),
    .invalid_move  (invalid_move),
    .target_row    (target_row),
    .col_full      (col_full),
    .board_full    (board_full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: apply the game rules to the inputs about to be sampled.
  task automatic model();
    int  n_full;
    int  c;
    bit  ok;
    if (!rst) begin
      exp_valid   = 0;
      exp_invalid = 0;
      exp_row     = 0;
      exp_full    = 0;
      exp_board   = 0;
    end else begin
      n_full = 0;
      for (int i = 0; i < COLS; i++) begin
        exp_full[i] = (int'(cap[i]) >= ROWS);
        if (exp_full[i]) n_full++;
      end
      exp_board = (n_full == COLS);
      ok = 0;
      c  = int'(selected_move);
      if (c < COLS) ok = (int'(cap[c]) < ROWS);
      exp_valid   = move_req && ok;
      exp_invalid = move_req && !ok;
      if (move_req && ok) exp_row = cap[c];
    end
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (valid_move === exp_valid) else begin
      errors++;
      $error("FAIL %s valid_move got %b want %b", tag, valid_move, exp_valid);
    end
    checks++;
    assert (invalid_move === exp_invalid) else begin
      errors++;
      $error("FAIL %s invalid_move got %b want %b", tag, invalid_move, exp_invalid);
    end
    checks++;
    assert (target_row === exp_row) else begin
      errors++;
      $error("FAIL %s target_row got %0d want %0d", tag, target_row, exp_row);
    end
    checks++;
    assert (col_full === exp_full) else begin
      errors++;
      $error("FAIL %s col_full got %b want %b", tag, col_full, exp_full);
    end
    checks++;
    assert (board_full === exp_board) else begin
      errors++;
      $error("FAIL %s board_full got %b want %b", tag, board_full, exp_board);
    end
    checks++;
    assert (!(valid_move && invalid_move)) else begin
      errors++;
      $error("FAIL %s both_pulses got %b%b want not 11", tag, valid_move, invalid_move);
    end
  endtask

  // driver: one clock with the current inputs, then compare
  task automatic step(input string tag);
    model();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_caps(input logic [2:0] v);
    for (int i = 0; i < COLS; i++) cap[i] = v;
  endtask

  initial begin
    rst = 1'b0;
    move_req = 1'b1;
    selected_move = 3'd0;
    set_caps(3'd0);
    exp_row = 0;

    // reset held with a pending request
    step("reset0");
    step("reset1");
    // first request after release
    rst = 1'b1;
    step("post_reset_req");
    // fixed-value spot checks of the reset test
    checks++;
    assert (valid_move === 1'b1 && target_row === 3'd0) else begin
      errors++;
      $error("FAIL post_reset_fixed got v=%b row=%0d want v=1 row=0", valid_move, target_row);
    end

    // normal drop
    cap[3] = 3'd4; selected_move = 3'd3; move_req = 1'b1;
    step("normal_drop");
    checks++;
    assert (target_row === 3'd4) else begin
      errors++;
      $error("FAIL normal_drop_row got %0d want 4", target_row);
    end
    move_req = 1'b0;
    step("idle_hold");

    // full column
    cap[5] = 3'd6; selected_move = 3'd5; move_req = 1'b1;
    step("full_col");

    // bad index, then out-of-range cap
    selected_move = 3'd7;
    step("bad_index");
    set_caps(3'd0);
    cap[0] = 3'd7; selected_move = 3'd0;
    step("bad_cap");

    // board full, then one column opens
    set_caps(3'd6); move_req = 1'b0;
    step("board_full");
    checks++;
    assert (col_full === 7'b1111111 && board_full === 1'b1) else begin
      errors++;
      $error("FAIL board_full_fixed got %b/%b want 1111111/1", col_full, board_full);
    end
    cap[2] = 3'd5;
    step("board_open");
    move_req = 1'b1; selected_move = 3'd2;
    step("board_last_slot");

    // exhaustive sweep, request held high
    set_caps(3'd0);
    for (int c = 0; c < COLS; c++) begin
      for (int v = 0; v < ROWS + 1; v++) begin
        cap[c] = 3'(v);
        selected_move = 3'(c);
        move_req = 1'b1;
        step($sformatf("sweep_c%0d_v%0d", c, v));
      end
      cap[c] = 3'd0;
    end

    // random traffic with occasional reset
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 19) != 0);
      move_req = ($urandom_range(0, 3) != 0);
      selected_move = 3'($urandom_range(0, 7));
      for (int i = 0; i < COLS; i++) begin
        cap[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(5, 7))
                                             : 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) set_caps(3'($urandom_range(6, 7)));
      step($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/check_move.md
Name: check_move

Overview:
- Registered legality checker for Connect-4 drops, in a 6-row × 7-column board controller.
- Takes the currently selected column index and the seven per-column fill counts (capacities).
- Reports whether a drop into the selected column is legal and which row the piece would land in.
- Also publishes per-column full flags and a board-full flag, used by the controller's draw check.

Parameters:
ROWS  6  cells per column; a column with cap >= ROWS is full
COLS  7  number of columns; legal column indices are 0..COLS-1
CW    3  width of the column index and of each capacity count

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-low reset
move_req  input  1  active-high request strobe: evaluate selected_move this cycle
selected_move  input  CW  column index chosen by the player
col0_cap  input  CW  pieces currently in column 0 (0..6)
col1_cap  input  CW  pieces in column 1
col2_cap  input  CW  pieces in column 2
col3_cap  input  CW  pieces in column 3
col4_cap  input  CW  pieces in column 4
col5_cap  input  CW  pieces in column 5
col6_cap  input  CW  pieces in column 6
valid_move  output  1  one-cycle pulse: the requested drop is legal
invalid_move  output  1  one-cycle pulse: the requested drop is illegal
target_row  output  CW  landing row (= cap of the selected column) for the last valid request
col_full  output  COLS  bit i set when col{i}_cap >= ROWS
board_full  output  1  all columns full

Behaviour:
- All state updates on the rising edge of clk.
- Reset: rst==0 at a rising edge forces valid_move=0, invalid_move=0, target_row=0, col_full=0, board_full=0. Reset has priority over move_req. A request sampled in the same cycle as reset is discarded.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- When move_req==1 at an edge:
  - selected_move >= COLS (value 7) -> invalid_move=1, valid_move=0, target_row unchanged.
  - Otherwise cap = col{selected_move}_cap.
  - cap >= ROWS (6 or 7) -> invalid_move=1, valid_move=0, target_row unchanged.
  - Else valid_move=1, invalid_move=0, target_row=cap.
- When move_req==0 at an edge: valid_move=0, invalid_move=0, target_row holds its value.
- valid_move and invalid_move are never both 1. Each is high for exactly one cycle per sampled request. Holding move_req high re-evaluates and re-pulses every cycle.
- col_full and board_full are registered every cycle, independent of move_req:
  - col_full[i] = (col{i}_cap >= ROWS).
  - board_full = AND of all col_full bits.
- Caps are unsigned. Cap value 7 (out of range) is treated as full.
- The block makes no assumption about caps changing between cycles; it always uses the values sampled at the same edge.
- No internal state beyond the output registers. There is no handshake beyond the move_req strobe.

Decomposition:
- Shared package con4_pkg holds:
  - ROWS, COLS, CW constants.
  - Cell encoding: EMPTY=2'b00, P1=2'b01, P2=2'b10, DRAW_FILL=2'b11.
  - Controller state encoding (P1_MOVE, CHECK_1_WIN, WIN1, P2_MOVE, CHECK_2_WIN, WIN2, CHECK_DRAW, DRAW = 0..7).
- One combinational sub-module, col_cap_mux: selects the cap for the chosen column and flags index >= COLS. check_move instantiates it once and adds the comparison logic and output registers.

Test Plan:
- Reset: rst=0 for 2 cycles with move_req=1, selected_move=0, all caps 0 -> all outputs 0; after release plus one request, valid_move=1, target_row=0.
- Normal drop: caps all 0 except col3_cap=4, move_req=1, selected_move=3 -> next cycle valid_move=1, invalid_move=0, target_row=4; with move_req=0 the following cycle, valid_move=0 and target_row stays 4.
- Full column: col5_cap=6, move_req=1, selected_move=5 -> invalid_move=1, valid_move=0, target_row unchanged; col_full[5]=1.
- Bad index and bad cap: selected_move=7 with move_req=1 -> invalid_move=1. Separately, col0_cap=7 with selected_move=0 -> invalid_move=1 and col_full[0]=1.
- Board full: all caps=6 -> col_full=7'b1111111, board_full=1; lowering col2_cap to 5 -> board_full=0 and col_full[2]=0 next cycle.
- Sweep: for each column 0..6 and each cap 0..6, one request each -> valid_move iff cap<6, with target_row=cap; exactly one of valid_move/invalid_move pulses per request.
